// File: rtl/rosc_odometer_seq.sv
// Stress/measure sequencer for a ring-oscillator odometer array: drives the array controls
// and counts synchronised edges of one selected oscillator over a programmable window.
module rosc_odometer_seq #(
    parameter int NUM_ROSC   = 3,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8,
    localparam int SEL_W     = $clog2(NUM_ROSC)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic                ABORT,
    input  logic [1:0]          MODE,
    input  logic [SEL_W-1:0]    SEL,
    input  logic [WIN_W-1:0]    WIN_LEN,
    input  logic [NUM_ROSC-1:0] ROSC_OUT,
    input  logic                COUNT_READY,
    output logic [NUM_ROSC-1:0] EN_POWER_ROSC,
    output logic [NUM_ROSC-1:0] SEL_ONEHOT,
    output logic                EN_ROSC,
    output logic                MEAS_STRESS,
    output logic                AC_DC,
    output logic                ROSC_START,
    output logic                BUSY,
    output logic [CNT_W-1:0]    COUNT,
    output logic                COUNT_VALID,
    output logic                OVF,
    output logic                SEL_ERR,
    output logic [2:0]          state_dbg
);

    localparam int TMR_W = (WIN_W > $clog2(SETTLE_CYC + 1)) ? WIN_W : $clog2(SETTLE_CYC + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_STRESS, S_SETTLE, S_RUN, S_HOLD} state_t;

    state_t              state, state_n;
    logic                ac_q, ac_n;
    logic [SEL_W-1:0]    sel_q, sel_n;
    logic [WIN_W-1:0]    win_q, win_n;
    logic [TMR_W-1:0]    tmr, tmr_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                ovf, ovf_n;
    logic [CNT_W-1:0]    count_n, count_acc, count_acc_n;
    logic                ovf_out_n, sel_err_n;
    logic                sync1, sync2, sync3, edge_det;
    logic                sel_ok;
    logic [TMR_W-1:0]    win_last;
    logic [NUM_ROSC-1:0] onehot_n, en_power_n, sel_onehot_n;
    logic                en_rosc_n, meas_n, ac_dc_n, rosc_start_n;

    assign edge_det  = sync2 & ~sync3;
    assign sel_ok    = {1'b0, SEL} < (SEL_W + 1)'(NUM_ROSC);
    assign win_last  = TMR_W'(win_q) - TMR_W'(1);
    assign state_dbg = state;

    always_comb begin
        state_n     = state;
        ac_n        = ac_q;
        sel_n       = sel_q;
        win_n       = win_q;
        tmr_n       = tmr;
        cnt_n       = cnt;
        ovf_n       = ovf;
        count_n     = COUNT;
        count_acc_n = count_acc;
        ovf_out_n   = OVF;
        sel_err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (START && !ABORT) begin
                    case (MODE)
                        2'b01, 2'b10: begin
                            state_n = S_STRESS;
                            ac_n    = MODE[1];
                        end
                        2'b11: begin
                            if (sel_ok) begin
                                state_n = S_SETTLE;
                                sel_n   = SEL;
                                win_n   = WIN_LEN;
                                tmr_n   = '0;
                                cnt_n   = '0;
                                ovf_n   = 1'b0;
                            end else begin
                                sel_err_n = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_STRESS: ;
            S_SETTLE: begin
                if (tmr == SETTLE_LAST) begin
                    tmr_n = '0;
                    if (win_q == '0) begin
                        state_n   = S_HOLD;
                        count_n   = '0;
                        ovf_out_n = 1'b0;
                    end else begin
                        state_n = S_RUN;
                    end
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            S_RUN: begin
                // Saturate rather than wrap; OVF flags that at least one edge was lost.
                if (edge_det) begin
                    if (&cnt) ovf_n = 1'b1;
                    else      cnt_n = cnt + CNT_W'(1);
                end
                if (tmr == win_last) begin
                    state_n   = S_HOLD;
                    count_n   = cnt_n;
                    ovf_out_n = ovf_n;
                end else begin
                    tmr_n = tmr + TMR_W'(1);
                end
            end
            S_HOLD: begin
                if (COUNT_READY) begin
                    state_n     = S_IDLE;
                    ovf_out_n   = 1'b0;
                    count_acc_n = COUNT;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Abort discards any unaccepted result so COUNT shows the last accepted one.
        if (ABORT && state != S_IDLE) begin
            state_n     = S_IDLE;
            count_n     = count_acc;
            count_acc_n = count_acc;
            ovf_out_n   = 1'b0;
        end
    end

    always_comb begin
        onehot_n     = NUM_ROSC'(1) << sel_n;
        en_power_n   = '0;
        sel_onehot_n = '0;
        en_rosc_n    = 1'b0;
        meas_n       = 1'b0;
        ac_dc_n      = 1'b0;
        rosc_start_n = 1'b0;
        case (state_n)
            S_STRESS: begin
                en_power_n   = '1;
                ac_dc_n      = ac_n;
                rosc_start_n = 1'b1;
            end
            S_SETTLE, S_RUN: begin
                en_power_n   = onehot_n;
                sel_onehot_n = onehot_n;
                en_rosc_n    = 1'b1;
                meas_n       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            ac_q          <= 1'b0;
            sel_q         <= '0;
            win_q         <= '0;
            tmr           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            count_acc     <= '0;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            EN_POWER_ROSC <= '0;
            SEL_ONEHOT    <= '0;
            EN_ROSC       <= 1'b0;
            MEAS_STRESS   <= 1'b0;
            AC_DC         <= 1'b0;
            ROSC_START    <= 1'b0;
            BUSY          <= 1'b0;
            COUNT         <= '0;
            COUNT_VALID   <= 1'b0;
            OVF           <= 1'b0;
            SEL_ERR       <= 1'b0;
        end else begin
            state         <= state_n;
            ac_q          <= ac_n;
            sel_q         <= sel_n;
            win_q         <= win_n;
            tmr           <= tmr_n;
            cnt           <= cnt_n;
            ovf           <= ovf_n;
            count_acc     <= count_acc_n;
            sync1         <= ROSC_OUT[sel_q];
            sync2         <= sync1;
            sync3         <= sync2;
            EN_POWER_ROSC <= en_power_n;
            SEL_ONEHOT    <= sel_onehot_n;
            EN_ROSC       <= en_rosc_n;
            MEAS_STRESS   <= meas_n;
            AC_DC         <= ac_dc_n;
            ROSC_START    <= rosc_start_n;
            BUSY          <= (state_n != S_IDLE);
            COUNT         <= count_n;
            COUNT_VALID   <= (state_n == S_HOLD);
            OVF           <= ovf_out_n;
            SEL_ERR       <= sel_err_n;
        end
    end

endmodule
